vec_dot_ctrl: RTL and testbench



---
 rtl/vec_pkg.sv | 20 ++
 rtl/vec_dot_ctrl_if.sv | 42 ++++
 rtl/vdc_lat_tracker.sv | 30 +++
 rtl/vec_dot_ctrl.sv | 104 ++++++++++
 tb/tb_vec_dot_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared types and width helpers for the vec_mul datapath and the controllers that feed it.
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vdc_state_e;

  // Full-precision width of one C-element chunk product sum.
  function automatic int vec_w_p(input int c, input int w_x, input int w_k);
    return w_x + w_k + $clog2(c);
  endfunction

  function automatic int vec_w_acc(input int c, input int w_x, input int w_k, input int max_chunks);
    return vec_w_p(c, w_x, w_k) + $clog2(max_chunks);
  endfunction

endpackage

// File: rtl/vec_dot_ctrl_if.sv
// Bundle of the command, chunk, datapath and result ports of vec_dot_ctrl.
interface vec_dot_ctrl_if
  import vec_pkg::*;
#(
  parameter int C          = 8,
  parameter int W_X        = 8,
  parameter int W_K        = 8,
  parameter int MAX_CHUNKS = 16
);
  localparam int W_P   = vec_w_p(C, W_X, W_K);
  localparam int W_CNT = $clog2(MAX_CHUNKS + 1);
  localparam int W_ACC = vec_w_acc(C, W_X, W_K, MAX_CHUNKS);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // the producer holds its payload stable while valid is high and ready is low.
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [W_CNT-1:0]              cmd_chunks;
  logic                          in_valid;
  logic                          in_ready;
  logic [C-1:0][W_K-1:0]         in_k;
  logic [C-1:0][W_X-1:0]         in_x;
  logic                          dp_en;
  logic [C-1:0][W_K-1:0]         dp_k;
  logic [C-1:0][W_X-1:0]         dp_x;
  logic signed [W_P-1:0]         dp_y;
  logic                          res_valid;
  logic                          res_ready;
  logic signed [W_ACC-1:0]       res_data;
  logic                          busy;

  modport slave (
    input  cmd_valid, cmd_chunks, in_valid, in_k, in_x, dp_y, res_ready,
    output cmd_ready, in_ready, dp_en, dp_k, dp_x, res_valid, res_data, busy
  );

  modport master (
    output cmd_valid, cmd_chunks, in_valid, in_k, in_x, dp_y, res_ready,
    input  cmd_ready, in_ready, dp_en, dp_k, dp_x, res_valid, res_data, busy
  );

endinterface

// File: rtl/vdc_lat_tracker.sv
// Valid shift register that mirrors the datapath latency: a bit pushed at issue
// pops out in the cycle the matching partial sum is valid.
module vdc_lat_tracker #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o,
  output logic pending_o
);
  localparam logic [DEPTH-1:0] LOW_MASK = {DEPTH{1'b1}} >> 1;

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d = DEPTH'({sr_q, in_i});
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  // pending_o: something is still in flight beyond the stage popping out now.
  assign out_o     = sr_q[DEPTH-1];
  assign pending_o = |(sr_q & LOW_MASK);

endmodule

// File: rtl/vec_dot_ctrl.sv
// Sequencer for the vec_mul dot-product datapath: streams chunks, tracks in-flight
// partial sums and accumulates them into one full-precision signed result.
module vec_dot_ctrl
  import vec_pkg::*;
#(
  parameter int C          = 8,
  parameter int W_X        = 8,
  parameter int W_K        = 8,
  parameter int MAX_CHUNKS = 16,
  parameter int DP_LAT     = 1
) (
  input  logic             clk,
  input  logic             rst,
  vec_dot_ctrl_if.slave    bus,
  output vdc_state_e       dbg_state
);
  localparam int W_P   = vec_w_p(C, W_X, W_K);
  localparam int W_CNT = $clog2(MAX_CHUNKS + 1);
  localparam int W_ACC = vec_w_acc(C, W_X, W_K, MAX_CHUNKS);
  localparam logic [W_CNT-1:0] MAX_N = W_CNT'(MAX_CHUNKS);

  vdc_state_e              state_q, state_d;
  logic [W_CNT-1:0]        n_q, n_d;
  logic [W_CNT-1:0]        issued_q, issued_d;
  logic signed [W_ACC-1:0] acc_q, acc_d;

  logic [W_CNT-1:0]        cmd_n;
  logic                    cmd_take;
  logic                    in_rdy;
  logic                    accept;
  logic                    last_accept;
  logic                    trk_out;
  logic                    trk_pending;
  logic signed [W_ACC-1:0] dp_y_ext;

  assign cmd_n       = (bus.cmd_chunks > MAX_N) ? MAX_N : bus.cmd_chunks;
  assign cmd_take    = (state_q == IDLE) && bus.cmd_valid && !rst;
  assign in_rdy      = (state_q == LOAD) && (issued_q < n_q) && !rst;
  assign accept      = in_rdy && bus.in_valid;
  assign last_accept = accept && ((issued_q + W_CNT'(1)) == n_q);
  assign dp_y_ext    = {{(W_ACC-W_P){bus.dp_y[W_P-1]}}, bus.dp_y};
  assign dbg_state   = state_q;

  vdc_lat_tracker #(.DEPTH(DP_LAT)) u_trk (
    .clk       (clk),
    .rst       (rst),
    .in_i      (accept),
    .out_o     (trk_out),
    .pending_o (trk_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      issued_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      issued_q <= issued_d;
      acc_q    <= acc_d;
    end
  end

  // DRAIN may leave while the final partial sum is still being captured this
  // cycle; dp_en stays high for that capture because we are still in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_take) state_d = (cmd_n == '0) ? DONE : LOAD;
      LOAD:    if (last_accept) state_d = DRAIN;
      DRAIN:   if (!trk_pending) state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    n_d      = n_q;
    issued_d = issued_q;
    acc_d    = acc_q;
    if (cmd_take) begin
      n_d      = cmd_n;
      issued_d = '0;
      acc_d    = '0;
    end
    if (accept)  issued_d = issued_q + W_CNT'(1);
    if (trk_out) acc_d    = acc_q + dp_y_ext;
  end

  // Operands are gated by the accept strobe so a bubble issues a zero product.
  always_comb begin
    bus.cmd_ready = (state_q == IDLE) && !rst;
    bus.in_ready  = in_rdy;
    bus.dp_en     = (state_q == LOAD) || (state_q == DRAIN);
    bus.dp_k      = accept ? bus.in_k : '0;
    bus.dp_x      = accept ? bus.in_x : '0;
    bus.res_valid = (state_q == DONE);
    bus.res_data  = (state_q == DONE) ? acc_q : '0;
    bus.busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_vec_dot_ctrl.sv
// Bench for vec_dot_ctrl: behavioural datapath, directed boundary cases and random
// commands, with results checked by a queue-based scoreboard.
module tb_vec_dot_ctrl;
  import vec_pkg::*;

  localparam int C          = 8;
  localparam int W_X        = 8;
  localparam int W_K        = 8;
  localparam int MAX_CHUNKS = 16;
  localparam int DP_LAT     = 1;
  localparam int W_P        = vec_w_p(C, W_X, W_K);
  localparam int W_CNT      = $clog2(MAX_CHUNKS + 1);
  localparam int W_ACC      = vec_w_acc(C, W_X, W_K, MAX_CHUNKS);

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  vdc_state_e dbg_state;

  logic [W_ACC-1:0]      exp_q[$];
  logic [W_ACC-1:0]      mon_exp;
  logic [C-1:0][W_K-1:0] k_arr [MAX_CHUNKS];
  logic [C-1:0][W_X-1:0] x_arr [MAX_CHUNKS];
  logic [W_P-1:0]        dp_pipe [DP_LAT];

  vec_dot_ctrl_if #(.C(C), .W_X(W_X), .W_K(W_K), .MAX_CHUNKS(MAX_CHUNKS)) bus ();

  vec_dot_ctrl #(
    .C(C), .W_X(W_X), .W_K(W_K), .MAX_CHUNKS(MAX_CHUNKS), .DP_LAT(DP_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: registered full-width chunk sum, zero while disabled.
  function automatic logic [W_P-1:0] chunk_sum(input logic [C-1:0][W_K-1:0] k,
                                               input logic [C-1:0][W_X-1:0] x);
    longint s = 0;
    for (int e = 0; e < C; e++) s += longint'($signed(k[e])) * longint'($signed(x[e]));
    return W_P'(s);
  endfunction

  always @(posedge clk) begin
    dp_pipe[0] <= bus.dp_en ? chunk_sum(bus.dp_k, bus.dp_x) : '0;
    for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign bus.dp_y = dp_pipe[DP_LAT-1];

  // Reference: dot product of the first min(chunks, MAX_CHUNKS) chunks.
  function automatic logic [W_ACC-1:0] model(input int chunks);
    longint s = 0;
    int n = (chunks > MAX_CHUNKS) ? MAX_CHUNKS : chunks;
    for (int c = 0; c < n; c++)
      for (int e = 0; e < C; e++)
        s += longint'($signed(k_arr[c][e])) * longint'($signed(x_arr[c][e]));
    return W_ACC'(s);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got %0d expected none", $signed(bus.res_data));
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.res_data !== mon_exp) begin
          n_fail++;
          $display("FAIL result: got %0d expected %0d", $signed(bus.res_data), $signed(mon_exp));
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < MAX_CHUNKS; i++)
      for (int e = 0; e < C; e++) begin
        k_arr[i][e] = W_K'($urandom_range(0, (1 << W_K) - 1));
        x_arr[i][e] = W_X'($urandom_range(0, (1 << W_X) - 1));
      end
  endtask

  task automatic send_cmd(input int chunks, input logic [W_ACC-1:0] exp, output int t);
    int g = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_chunks = W_CNT'(chunks);
    @(negedge clk);
    while (!bus.cmd_ready && g < 300) begin
      g++;
      @(negedge clk);
    end
    check("cmd_accepted", longint'(bus.cmd_ready), 1);
    t = cyc;
    exp_q.push_back(exp);
    step();
    bus.cmd_valid  = 1'b0;
    bus.cmd_chunks = '0;
  endtask

  task automatic send_chunks(input int n, input int max_bubble);
    int i = 0;
    int guard = 0;
    int nb;
    bit took;
    while (i < n && guard < 400) begin
      nb = (max_bubble > 0) ? $urandom_range(0, max_bubble) : 0;
      repeat (nb) begin
        bus.in_valid = 1'b0;
        bus.in_k     = k_arr[(i + 3) % MAX_CHUNKS];
        bus.in_x     = ~x_arr[i];
        step();
        guard++;
      end
      bus.in_valid = 1'b1;
      bus.in_k     = k_arr[i];
      bus.in_x     = x_arr[i];
      @(negedge clk);
      took = bus.in_ready;
      step();
      guard++;
      if (took) i++;
    end
    bus.in_valid = 1'b0;
    bus.in_k     = '0;
    bus.in_x     = '0;
    check("chunks_accepted", i, n);
  endtask

  task automatic wait_result(input int stall, output int first);
    int g = 0;
    bus.res_ready = (stall == 0);
    @(negedge clk);
    while (!bus.res_valid && g < 300) begin
      g++;
      @(negedge clk);
    end
    first = cyc;
    check("res_valid_seen", longint'(bus.res_valid), 1);
    if (stall > 0) begin
      repeat (stall) step();
      bus.res_ready = 1'b1;
      @(negedge clk);
    end
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, longint'(bus.cmd_ready), 1);
    check({tag, "_in_ready"},  longint'(bus.in_ready), 0);
    check({tag, "_dp_en"},     longint'(bus.dp_en), 0);
    check({tag, "_dp_k"},      longint'(bus.dp_k), 0);
    check({tag, "_dp_x"},      longint'(bus.dp_x), 0);
    check({tag, "_res_valid"}, longint'(bus.res_valid), 0);
    check({tag, "_res_data"},  longint'(bus.res_data), 0);
    check({tag, "_busy"},      longint'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int first;
    int chunks;
    logic [W_ACC-1:0] e_val;

    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_chunks = '0;
    bus.in_valid   = 1'b0;
    bus.in_k       = '0;
    bus.in_x       = '0;
    bus.res_ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cmd_ready_in_reset", longint'(bus.cmd_ready), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    check("post_reset_state", longint'(dbg_state), longint'(IDLE));
    step();

    // two all-ones chunks back-to-back
    for (int i = 0; i < MAX_CHUNKS; i++) begin
      k_arr[i] = {C{W_K'(1)}};
      x_arr[i] = {C{W_X'(1)}};
    end
    send_cmd(2, W_ACC'(16), t);
    send_chunks(2, 0);
    wait_result(0, first);
    check("ones_res_valid_cycle", first, t + 2 + DP_LAT + 1);

    // full-length most-negative operands
    for (int i = 0; i < MAX_CHUNKS; i++) begin
      k_arr[i] = {C{8'h80}};
      x_arr[i] = {C{8'h80}};
    end
    send_cmd(16, W_ACC'(2097152), t);
    send_chunks(16, 0);
    wait_result(0, first);
    check("max_res_valid_cycle", first, t + 16 + DP_LAT + 1);

    // chunk sums 5, -7, 20 with two-cycle bubbles carrying garbage operands
    for (int i = 0; i < 3; i++) begin
      k_arr[i] = '0;
      x_arr[i] = '0;
    end
    k_arr[0][0] = 8'd5;   x_arr[0][0] = 8'd1;
    k_arr[1][0] = 8'hF9;  x_arr[1][0] = 8'd1;
    k_arr[2][0] = 8'd4;   x_arr[2][0] = 8'd5;
    send_cmd(3, W_ACC'(18), t);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_k     = k_arr[i];
      bus.in_x     = x_arr[i];
      @(negedge clk);
      check("bubble_in_ready", longint'(bus.in_ready), 1);
      step();
      if (i < 2) begin
        for (int b = 0; b < 2; b++) begin
          bus.in_valid = 1'b0;
          bus.in_k     = '1;
          bus.in_x     = '1;
          @(negedge clk);
          check("bubble_dp_k_zero", longint'(bus.dp_k), 0);
          check("bubble_dp_x_zero", longint'(bus.dp_x), 0);
          check("bubble_dp_en", longint'(bus.dp_en), 1);
          step();
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_k     = '0;
    bus.in_x     = '0;
    wait_result(0, first);

    // result held for 5 cycles while a zero-chunk command waits
    fill_random();
    e_val = model(1);
    send_cmd(1, e_val, t);
    send_chunks(1, 0);
    bus.res_ready  = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_chunks = '0;
    begin
      int g = 0;
      @(negedge clk);
      while (!bus.res_valid && g < 100) begin
        g++;
        @(negedge clk);
      end
    end
    for (int s = 0; s < 5; s++) begin
      check("stall_res_valid", longint'(bus.res_valid), 1);
      check("stall_res_data", longint'(bus.res_data), longint'(e_val));
      check("stall_cmd_ready", longint'(bus.cmd_ready), 0);
      step();
      @(negedge clk);
    end
    step();
    bus.res_ready = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    t = cyc;
    step();
    @(negedge clk);
    check("after_hs_cmd_ready", longint'(bus.cmd_ready), 1);
    check("after_hs_idle", longint'(bus.busy), 0);
    check("after_hs_cycle", cyc, t + 1);
    step();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("zero_cmd_res_valid", longint'(bus.res_valid), 1);
    check("zero_cmd_res_data", longint'(bus.res_data), 0);
    step();

    // clamp of an oversized command
    fill_random();
    send_cmd(20, model(20), t);
    send_chunks(16, 0);
    bus.in_valid = 1'b1;
    bus.in_k     = k_arr[0];
    bus.in_x     = x_arr[0];
    @(negedge clk);
    check("clamp_in_ready_low", longint'(bus.in_ready), 0);
    step();
    bus.in_valid = 1'b0;
    wait_result(0, first);

    // reset in the middle of LOAD
    fill_random();
    send_cmd(4, model(4), t);
    send_chunks(2, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check_reset_outputs("mid_load_reset");
    step();
    fill_random();
    send_cmd(1, model(1), t);
    send_chunks(1, 0);
    wait_result(0, first);

    // random commands, bubbles and result stalls
    for (int r = 0; r < 25; r++) begin
      fill_random();
      chunks = $urandom_range(0, 20);
      send_cmd(chunks, model(chunks), t);
      send_chunks((chunks > MAX_CHUNKS) ? MAX_CHUNKS : chunks, $urandom_range(0, 2));
      wait_result($urandom_range(0, 3), first);
    end

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
